// File: rtl/ahb_waitstate_ram_pkg.sv
// Shared AHB-Lite encodings and the subordinate state type for the wait-state RAM.
package ahb_waitstate_ram_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } sub_state_e;

endpackage

// File: rtl/ahb_waitstate_ram_bytewrite.sv
// DEPTH x XLEN flop array with per-byte write enables and asynchronous read.
module ahb_bytewrite_ram #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic [XLEN/8-1:0]        we,
   input  logic [$clog2(DEPTH)-1:0] idx,
   input  logic [XLEN-1:0]          wdata,
   output logic [XLEN-1:0]          rdata
);

   localparam int BYTES = XLEN / 8;

   // One independent byte-wide array per lane; contents are never reset.
   for (genvar b = 0; b < BYTES; b++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
         if (we[b]) lane_mem[idx] <= wdata[8*b +: 8];
      end

      assign rdata[8*b +: 8] = lane_mem[idx];
   end

endmodule

// File: rtl/ahb_waitstate_ram.sv
// AHB-Lite subordinate RAM with programmable wait states and two-cycle ERROR responses.
module ahb_waitstate_ram
   import ahb_waitstate_ram_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int PA_BITS     = 56,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   input  logic                HSEL,
   input  logic [PA_BITS-1:0]  HADDR,
   input  logic [1:0]          HTRANS,
   input  logic                HWRITE,
   input  logic [2:0]          HSIZE,
   input  logic                HREADY,
   input  logic [XLEN-1:0]     HWDATA,
   input  logic [XLEN/8-1:0]   HWSTRB,
   output logic [XLEN-1:0]     HRDATA,
   output logic                HREADYOUT,
   output logic                HRESP
);

   localparam int BYTES = XLEN / 8;
   localparam int OFF   = $clog2(BYTES);
   localparam int IDXW  = $clog2(DEPTH);
   localparam int WW    = PA_BITS - OFF;
   localparam int CW    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

   sub_state_e      state;
   logic [CW-1:0]   cnt;
   logic [IDXW-1:0] idx;
   logic            write;
   logic            ready;
   logic            resp;

   logic            active;
   logic            accept;
   logic [WW-1:0]   widx;
   logic [OFF-1:0]  amask;
   logic            err;
   logic [BYTES-1:0] we;
   logic [XLEN-1:0] rdata;

   always_comb begin
      active = 1'b0;
      case (HTRANS)
         HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
         HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
         default:                   active = 1'b0;
      endcase
   end

   assign accept = HSEL & HREADY & active;
   assign widx   = HADDR[PA_BITS-1:OFF];

   // Oversize, misaligned, or past-the-end word index; no wrap into low memory.
   always_comb begin
      amask = '0;
      for (int i = 0; i < OFF; i++) begin
         if (i < int'(HSIZE)) amask[i] = 1'b1;
      end
      err = (HSIZE > 3'(OFF)) | (|(HADDR[OFF-1:0] & amask)) | (widx >= WW'(DEPTH));
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state <= S_IDLE;
         cnt   <= '0;
         idx   <= '0;
         write <= 1'b0;
         ready <= 1'b1;
         resp  <= HRESP_OKAY;
      end else begin
         case (state)
            S_WAIT: begin
               if (cnt == '0) begin
                  state <= S_DATA;
                  ready <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_ERR1: begin
               state <= S_ERR2;
               ready <= 1'b1;
               resp  <= HRESP_ERROR;
            end
            default: begin
               // IDLE, DATA and ERR2 all present HREADYOUT high, so a new address phase may land here.
               if (accept) begin
                  idx   <= widx[IDXW-1:0];
                  write <= HWRITE;
                  if (err) begin
                     state <= S_ERR1;
                     ready <= 1'b0;
                     resp  <= HRESP_ERROR;
                  end else if (WAIT_STATES > 0) begin
                     state <= S_WAIT;
                     cnt   <= CW'(WAIT_STATES - 1);
                     ready <= 1'b0;
                     resp  <= HRESP_OKAY;
                  end else begin
                     state <= S_DATA;
                     ready <= 1'b1;
                     resp  <= HRESP_OKAY;
                  end
               end else begin
                  state <= S_IDLE;
                  ready <= 1'b1;
                  resp  <= HRESP_OKAY;
               end
            end
         endcase
      end
   end

   // Strobes are only honoured in a write's DATA cycle, and a reset edge drops the commit.
   assign we = (state == S_DATA && write && HRESETn) ? HWSTRB : '0;

   ahb_bytewrite_ram #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (HCLK),
      .we    (we),
      .idx   (idx),
      .wdata (HWDATA),
      .rdata (rdata)
   );

   assign HRDATA    = (state == S_DATA && !write) ? rdata : '0;
   assign HREADYOUT = ready;
   assign HRESP     = resp;

endmodule

// File: tb/tb_ahb_waitstate_ram.sv
// Scoreboard bench: two subordinates (2 wait states and zero-wait) driven by directed AHB transfers.
module tb_ahb_waitstate_ram;

   typedef struct {
      logic [63:0] rdata;
      logic        resp;
      int          stalls;
      int          id;
   } exp_t;

   logic        clk = 1'b0;
   logic        hresetn;
   logic        hsel      [2];
   logic [55:0] haddr     [2];
   logic [1:0]  htrans    [2];
   logic        hwrite    [2];
   logic [2:0]  hsize     [2];
   logic        hready    [2];
   logic [63:0] hwdata    [2];
   logic [7:0]  hwstrb    [2];
   logic [63:0] hrdata    [2];
   logic        hreadyout [2];
   logic        hresp     [2];

   exp_t q0[$];
   exp_t q1[$];
   int   tests = 0;
   int   fails = 0;
   int   next_id = 0;

   bit   in_data [2] = '{0, 0};
   int   stall   [2] = '{0, 0};
   int   nresp1  [2] = '{0, 0};

   always #5 clk = ~clk;

   assign hready[0] = hreadyout[0];
   assign hready[1] = hreadyout[1];

   ahb_waitstate_ram #(.XLEN(64), .PA_BITS(56), .DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
      .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
      .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HREADY(hready[0]), .HWDATA(hwdata[0]),
      .HWSTRB(hwstrb[0]), .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
   );

   ahb_waitstate_ram #(.XLEN(64), .PA_BITS(56), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
      .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
      .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HREADY(hready[1]), .HWDATA(hwdata[1]),
      .HWSTRB(hwstrb[1]), .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
   );

   task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s id=%0d got=%h expected=%h", nm, id, act, exp);
      end
   endtask

   // Completion monitor: a data phase ends on the first HREADYOUT-high cycle after its accept.
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (!hresetn) begin
            if (in_data[d]) begin
               in_data[d] = 0;
               if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
         end else begin
            if (in_data[d]) begin
               if (!hreadyout[d]) begin
                  stall[d]++;
                  if (hresp[d]) nresp1[d]++;
               end else begin
                  in_data[d] = 0;
                  if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                     tests++; fails++;
                     $display("FAIL unexpected_completion dut=%0d", d);
                  end else begin
                     if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                     chk("hresp", e.id, 64'(hresp[d]), 64'(e.resp));
                     chk("hrdata", e.id, hrdata[d], e.rdata);
                     chk("stall_cycles", e.id, 64'(stall[d]), 64'(e.stalls));
                     chk("stall_hresp", e.id, 64'(nresp1[d]), e.resp ? 64'(e.stalls) : 64'd0);
                  end
               end
            end
            if (hsel[d] && hready[d] && htrans[d][1]) begin
               in_data[d] = 1;
               stall[d]   = 0;
               nresp1[d]  = 0;
            end
         end
      end
   end

   task automatic issue(input int d, input logic wr, input logic [55:0] a, input logic [2:0] sz,
                        input logic [63:0] wd, input logic [7:0] st,
                        input logic [63:0] erd, input logic eresp, input int est);
      exp_t e;
      int   w;
      bit   acc;
      e.rdata = erd; e.resp = eresp; e.stalls = est; e.id = next_id++;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      hsel[d] = 1'b1; haddr[d] = a; htrans[d] = 2'b10; hwrite[d] = wr; hsize[d] = sz;
      acc = 0; w = 0;
      while (!acc && w < 20) begin
         @(negedge clk);
         acc = hready[d];
         @(posedge clk); #1;
         w++;
      end
      if (!acc) begin
         tests++; fails++;
         $display("FAIL accept_timeout id=%0d got=not_accepted expected=accepted", e.id);
      end
      hsel[d] = 1'b0; htrans[d] = 2'b00;
      if (wr) begin
         hwdata[d] = wd; hwstrb[d] = st;
      end else begin
         hwdata[d] = {$urandom, $urandom}; hwstrb[d] = 8'hFF;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("queue_drained", -1, 64'(q0.size() + q1.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      hresetn = 1'b0;
      for (int d = 0; d < 2; d++) begin
         hsel[d] = 0; haddr[d] = '0; htrans[d] = 2'b00; hwrite[d] = 0;
         hsize[d] = 3'd3; hwdata[d] = '0; hwstrb[d] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset_hreadyout", d, 64'(hreadyout[d]), 64'd1);
         chk("reset_hresp", d, 64'(hresp[d]), 64'd0);
         chk("reset_hrdata", d, hrdata[d], 64'd0);
      end
      @(posedge clk); #1;
      hresetn = 1'b1;

      // dut 0: two wait states
      issue(0, 1, 56'h0,    3'd3, 64'h1122334455667788, 8'hFF, 64'h0, 0, 2);
      issue(0, 0, 56'h0,    3'd3, 64'h0, 8'h00, 64'h1122334455667788, 0, 2);
      issue(0, 1, 56'h3,    3'd0, 64'hDEADBEEFABCDEF01, 8'h08, 64'h0, 0, 2);
      issue(0, 0, 56'h0,    3'd3, 64'h0, 8'h00, 64'h11223344AB667788, 0, 2);
      issue(0, 1, 56'h2,    3'd2, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1, 1);
      issue(0, 0, 56'h0,    3'd3, 64'h0, 8'h00, 64'h11223344AB667788, 0, 2);
      issue(0, 1, 56'h1FF8, 3'd3, 64'hCAFEF00D12345678, 8'hFF, 64'h0, 0, 2);
      issue(0, 0, 56'h1FF8, 3'd3, 64'h0, 8'h00, 64'hCAFEF00D12345678, 0, 2);
      issue(0, 0, 56'h2000, 3'd3, 64'h0, 8'h00, 64'h0, 1, 1);
      issue(0, 1, 56'h2000, 3'd3, 64'h5555555555555555, 8'hFF, 64'h0, 1, 1);
      issue(0, 0, 56'h0,    3'd3, 64'h0, 8'h00, 64'h11223344AB667788, 0, 2);
      issue(0, 0, 56'h0,    3'd4, 64'h0, 8'h00, 64'h0, 1, 1);
      issue(0, 0, 56'h4,    3'd2, 64'h0, 8'h00, 64'h11223344AB667788, 0, 2);
      drain();

      // dut 1: zero wait, pipelined back-to-back
      issue(1, 1, 56'h8, 3'd3, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 0, 0);
      issue(1, 0, 56'h8, 3'd3, 64'h0, 8'h00, 64'h0123456789ABCDEF, 0, 0);
      issue(1, 1, 56'h8, 3'd1, 64'hFFFFFFFFFFFF5AA5, 8'h03, 64'h0, 0, 0);
      issue(1, 0, 56'h8, 3'd3, 64'h0, 8'h00, 64'h0123456789AB5AA5, 0, 0);
      issue(1, 0, 56'h4, 3'd3, 64'h0, 8'h00, 64'h0, 1, 1);
      issue(1, 0, 56'h8, 3'd3, 64'h0, 8'h00, 64'h0123456789AB5AA5, 0, 0);
      drain();

      // dut 0: reset lands in the WAIT state of a write; the write must be dropped
      issue(0, 1, 56'h0, 3'd3, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 0, 2);
      hresetn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midreset_hreadyout", 0, 64'(hreadyout[0]), 64'd1);
      chk("midreset_hresp", 0, 64'(hresp[0]), 64'd0);
      chk("midreset_hrdata", 0, hrdata[0], 64'd0);
      @(posedge clk); #1;
      hresetn = 1'b1;
      issue(0, 0, 56'h0, 3'd3, 64'h0, 8'h00, 64'h11223344AB667788, 0, 2);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
